// File: rtl/speaker_i2s_tx_pkg.sv
// Shared types and constants for the speaker I2S playback path.
// State encoding, I2S frame geometry and G.711 mu-law decode constants.
package speaker_i2s_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int FRAME_BITS = 32;
  localparam int SLOT_BITS  = 16;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [15:0] MULAW_BIAS = 16'h0084;
  localparam int          MULAW_MAX  = 32124;

endpackage

// File: rtl/speaker_i2s_tx_mlaw2lin.sv
// G.711 mu-law byte to 16-bit linear PCM; purely combinational, no backpressure.
// Inverse of the linear-to-mu-law encoder on the capture side.
module speaker_i2s_tx_mlaw2lin
  import speaker_i2s_tx_pkg::*;
(
  input  logic [7:0]           mlaw,
  output logic [SLOT_BITS-1:0] lin
);

  logic [7:0]  u;
  logic [2:0]  e;
  logic [3:0]  m;
  logic [15:0] biased;
  logic [15:0] mag_raw;
  logic [14:0] mag;

  assign u       = ~mlaw;
  assign e       = u[6:4];
  assign m       = u[3:0];
  assign biased  = ({9'd0, m, 3'd0} + MULAW_BIAS) << e;
  assign mag_raw = biased - MULAW_BIAS;
  // Every legal code already lands at or below the G.711 ceiling; the clamp only pins the width.
  assign mag     = (mag_raw > 16'(MULAW_MAX)) ? 15'(MULAW_MAX) : mag_raw[14:0];
  assign lin     = u[7] ? (16'd0 - {1'b0, mag}) : {1'b0, mag};

endmodule

// File: rtl/speaker_i2s_tx.sv
// Mu-law word stream to Philips I2S master (mono sample on both slots), self-generated BCLK/LRCK.
// Two-word buffer (cur + hold skid); ready drops while hold is full; one sample fetched per frame.
module speaker_i2s_tx
  import speaker_i2s_tx_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play_start,
  input  logic        play_stop,
  input  logic [31:0] spk_data,
  input  logic        spk_data_valid,
  output logic        spk_data_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata,
  output logic        play_active,
  output logic        underrun
);

  localparam int                 DIV_W  = $clog2(BCLK_DIV);
  localparam logic [BIT_W-1:0]   LAST_B = BIT_W'(FRAME_BITS - 1);

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_cnt;
  logic                 bclk_q, lrck_q, sdata_q, underrun_q;
  logic                 stop_pend, fetch_pend, prev_lsb;
  logic [BIT_W-1:0]     b_q, b_nxt;
  logic [31:0]          cur_q, hold_q;
  logic                 cur_vld, hold_vld;
  logic [1:0]           k_q;
  logic [SLOT_BITS-1:0] smp_q, dec_lin;
  logic [7:0]           dec_in;
  logic [3:0]           bit_sel;
  logic                 div_wrap, bclk_fall, wrap_stop, enter, accept;

  assign div_wrap       = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign bclk_fall      = div_wrap && bclk_q;
  assign b_nxt          = b_q + BIT_W'(1);
  assign wrap_stop      = bclk_fall && (b_q == LAST_B) && (stop_pend || play_stop);
  assign play_active    = (state_q == ST_RUN);
  assign spk_data_ready = play_active && !hold_vld;
  assign accept         = spk_data_valid && spk_data_ready;
  // Slot bit b carries sample bit (16-b) mod 16, MSB one BCLK after the LRCK edge.
  assign bit_sel        = 4'd0 - b_nxt[3:0];

  always_comb begin
    dec_in = hold_q[31:24];
    if (cur_vld) begin
      case (k_q)
        2'd0: dec_in = cur_q[31:24];
        2'd1: dec_in = cur_q[23:16];
        2'd2: dec_in = cur_q[15:8];
        2'd3: dec_in = cur_q[7:0];
      endcase
    end
  end

  speaker_i2s_tx_mlaw2lin u_mlaw2lin (
    .mlaw (dec_in),
    .lin  (dec_lin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (play_start && !play_stop) state_d = ST_RUN;
      ST_RUN:  if (wrap_stop)                state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  assign enter = (state_q == ST_IDLE) && (state_d == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b1;
      sdata_q    <= 1'b0;
      b_q        <= LAST_B;
      stop_pend  <= 1'b0;
      fetch_pend <= 1'b0;
      prev_lsb   <= 1'b0;
      underrun_q <= 1'b0;
      cur_q      <= '0;
      cur_vld    <= 1'b0;
      hold_q     <= '0;
      hold_vld   <= 1'b0;
      k_q        <= '0;
      smp_q      <= '0;
    end else if (state_q == ST_IDLE || wrap_stop) begin
      // Idle and the stop wrap both park everything; entry arms the first fetch at b=31.
      div_cnt    <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b1;
      sdata_q    <= 1'b0;
      b_q        <= LAST_B;
      stop_pend  <= 1'b0;
      fetch_pend <= enter;
      prev_lsb   <= 1'b0;
      underrun_q <= 1'b0;
      cur_q      <= '0;
      cur_vld    <= 1'b0;
      hold_q     <= '0;
      hold_vld   <= 1'b0;
      k_q        <= '0;
      smp_q      <= '0;
    end else begin
      underrun_q <= 1'b0;
      fetch_pend <= bclk_fall && (b_nxt == LAST_B);
      if (play_stop) stop_pend <= 1'b1;

      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) bclk_q <= ~bclk_q;

      if (bclk_fall) begin
        b_q     <= b_nxt;
        lrck_q  <= b_nxt[BIT_W-1];
        sdata_q <= (b_nxt == '0) ? prev_lsb : smp_q[bit_sel];
      end

      // The right-slot LSB goes out after the fetch, so keep it aside.
      if (fetch_pend) begin
        prev_lsb <= smp_q[0];
        if (cur_vld) begin
          smp_q <= dec_lin;
          k_q   <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            cur_q    <= hold_q;
            cur_vld  <= hold_vld;
            hold_vld <= 1'b0;
          end
        end else if (hold_vld) begin
          cur_q    <= hold_q;
          cur_vld  <= 1'b1;
          k_q      <= 2'd1;
          smp_q    <= dec_lin;
          hold_vld <= 1'b0;
        end else begin
          smp_q      <= '0;
          underrun_q <= 1'b1;
        end
      end

      if (accept) begin
        hold_q   <= spk_data;
        hold_vld <= 1'b1;
      end
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = underrun_q;

endmodule
